// File: rtl/tty_writer.sv
// Character sink for a 25x80 byte text screen: prints, handles CR/LF/BS/FF,
// scrolls rows 1..24 over a 16-bit Wishbone master and drives a blink phase.
module tty_writer #(
    parameter logic [15:0] BASE      = 16'o0,
    parameter logic [23:0] FLASH_DIV = 24'd12500000
) (
    input  logic        wb_clk_i,
    input  logic        wb_rst_n_i,
    input  logic [7:0]  char_i,
    input  logic        char_stb_i,
    output logic        char_rdy_o,
    output logic [15:0] wbm_adr_o,
    output logic [15:0] wbm_dat_o,
    input  logic [15:0] wbm_dat_i,
    output logic        wbm_cyc_o,
    output logic        wbm_stb_o,
    output logic        wbm_we_o,
    output logic [1:0]  wbm_sel_o,
    input  logic        wbm_ack_i,
    output logic [10:0] cursor_o,
    output logic        cursor_on_o,
    output logic        flash_o
);

    typedef enum logic [2:0] {IDLE, WRCH, SCR_RD, SCR_WR, CLR} state_t;

    localparam logic [10:0] TEXT_START  = 11'd80;
    localparam logic [10:0] SCROLL_LAST = 11'd1918;
    localparam logic [10:0] TAIL_START  = 11'd1920;
    localparam logic [10:0] CLR_LAST    = 11'd1998;
    localparam logic [4:0]  LAST_ROW    = 5'd24;
    localparam logic [6:0]  LAST_COL    = 7'd79;

    state_t      state_reg;
    logic [4:0]  row_reg;
    logic [6:0]  col_reg;
    logic [10:0] cur_reg;
    logic [10:0] w_reg;
    logic [7:0]  char_reg;
    logic [15:0] data_reg;
    logic        clr_all_reg;
    logic        idle_reg;
    logic        cyc_reg;
    logic        we_reg;
    logic [1:0]  sel_reg;
    logic [15:0] adr_reg;
    logic [15:0] dat_reg;
    logic [23:0] flash_cnt_reg;
    logic        flash_reg;

    logic [10:0] req_addr;
    logic [1:0]  req_sel;
    logic        req_we;
    logic [15:0] req_dat;

    // Access the current state wants to issue once the bus has been idle a cycle.
    always_comb begin
        req_addr = cur_reg;
        req_sel  = 2'b11;
        req_we   = 1'b1;
        req_dat  = 16'h2020;
        case (state_reg)
            WRCH: begin
                req_sel = cur_reg[0] ? 2'b10 : 2'b01;
                req_dat = {char_reg, char_reg};
            end
            SCR_RD: begin
                req_addr = w_reg + TEXT_START;
                req_we   = 1'b0;
                req_dat  = 16'h0000;
            end
            SCR_WR: begin
                req_addr = w_reg;
                req_dat  = data_reg;
            end
            CLR:     req_addr = w_reg;
            default: ;
        endcase
    end

    always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
        if (!wb_rst_n_i) begin
            state_reg   <= IDLE;
            row_reg     <= 5'd1;
            col_reg     <= 7'd0;
            cur_reg     <= TEXT_START;
            w_reg       <= TEXT_START;
            char_reg    <= 8'd0;
            data_reg    <= 16'd0;
            clr_all_reg <= 1'b0;
            idle_reg    <= 1'b1;
            cyc_reg     <= 1'b0;
            we_reg      <= 1'b0;
            sel_reg     <= 2'b00;
            adr_reg     <= 16'd0;
            dat_reg     <= 16'd0;
        end else if (cyc_reg) begin
            if (wbm_ack_i) begin
                cyc_reg <= 1'b0;
                we_reg  <= 1'b0;
                case (state_reg)
                    WRCH: begin
                        if (col_reg != LAST_COL) begin
                            col_reg   <= col_reg + 7'd1;
                            cur_reg   <= cur_reg + 11'd1;
                            state_reg <= IDLE;
                            idle_reg  <= 1'b1;
                        end else if (row_reg != LAST_ROW) begin
                            col_reg   <= 7'd0;
                            row_reg   <= row_reg + 5'd1;
                            cur_reg   <= cur_reg + 11'd1;
                            state_reg <= IDLE;
                            idle_reg  <= 1'b1;
                        end else begin
                            col_reg     <= 7'd0;
                            cur_reg     <= cur_reg - 11'd79;
                            w_reg       <= TEXT_START;
                            clr_all_reg <= 1'b0;
                            state_reg   <= SCR_RD;
                        end
                    end
                    SCR_RD: begin
                        data_reg  <= wbm_dat_i;
                        state_reg <= SCR_WR;
                    end
                    SCR_WR: begin
                        if (w_reg == SCROLL_LAST) begin
                            w_reg     <= TAIL_START;
                            state_reg <= CLR;
                        end else begin
                            w_reg     <= w_reg + 11'd2;
                            state_reg <= SCR_RD;
                        end
                    end
                    CLR: begin
                        if (w_reg == CLR_LAST) begin
                            state_reg <= IDLE;
                            idle_reg  <= 1'b1;
                            if (clr_all_reg) begin
                                row_reg <= 5'd1;
                                col_reg <= 7'd0;
                                cur_reg <= TEXT_START;
                            end
                        end else begin
                            w_reg <= w_reg + 11'd2;
                        end
                    end
                    default: ;
                endcase
            end
        end else if (state_reg != IDLE) begin
            cyc_reg <= 1'b1;
            we_reg  <= req_we;
            sel_reg <= req_sel;
            adr_reg <= BASE + {5'd0, req_addr};
            dat_reg <= req_dat;
        end else if (char_stb_i) begin
            if (char_i >= 8'h20) begin
                char_reg  <= char_i;
                state_reg <= WRCH;
                idle_reg  <= 1'b0;
            end else begin
                case (char_i)
                    8'h0D: begin
                        col_reg <= 7'd0;
                        cur_reg <= cur_reg - {4'd0, col_reg};
                    end
                    8'h0A: begin
                        if (row_reg != LAST_ROW) begin
                            row_reg <= row_reg + 5'd1;
                            cur_reg <= cur_reg + 11'd80;
                        end else begin
                            w_reg       <= TEXT_START;
                            clr_all_reg <= 1'b0;
                            state_reg   <= SCR_RD;
                            idle_reg    <= 1'b0;
                        end
                    end
                    8'h08: begin
                        if (col_reg != 7'd0) begin
                            col_reg <= col_reg - 7'd1;
                            cur_reg <= cur_reg - 11'd1;
                        end
                    end
                    8'h0C: begin
                        w_reg       <= TEXT_START;
                        clr_all_reg <= 1'b1;
                        state_reg   <= CLR;
                        idle_reg    <= 1'b0;
                    end
                    default: ;
                endcase
            end
        end
    end

    always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
        if (!wb_rst_n_i) begin
            flash_cnt_reg <= 24'd0;
            flash_reg     <= 1'b0;
        end else if (flash_cnt_reg == FLASH_DIV - 24'd1) begin
            flash_cnt_reg <= 24'd0;
            flash_reg     <= ~flash_reg;
        end else begin
            flash_cnt_reg <= flash_cnt_reg + 24'd1;
        end
    end

    assign char_rdy_o  = idle_reg;
    assign cursor_on_o = idle_reg;
    assign cursor_o    = cur_reg;
    assign wbm_cyc_o   = cyc_reg;
    assign wbm_stb_o   = cyc_reg;
    assign wbm_we_o    = we_reg;
    assign wbm_sel_o   = sel_reg;
    assign wbm_adr_o   = adr_reg;
    assign wbm_dat_o   = dat_reg;
    assign flash_o     = flash_reg;

endmodule

// File: tb/tb_tty_writer.sv
// Bench for tty_writer: VRAM slave model, screen-level reference model,
// directed vector table, corner sequences and a randomized character stream.
module tb_tty_writer;

    localparam logic [15:0] BASE = 16'h0100;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic [7:0]  char_in = 8'd0;
    logic        char_stb = 1'b0;
    logic        rdy;
    logic [15:0] adr;
    logic [15:0] dat;
    logic [15:0] rdata = 16'd0;
    logic        cyc, stb, we;
    logic [1:0]  sel;
    logic        ack = 1'b0;
    logic [10:0] cursor;
    logic        cursor_on;
    logic        flash;

    tty_writer #(.BASE(BASE), .FLASH_DIV(24'd4)) dut (
        .wb_clk_i    (clk),
        .wb_rst_n_i  (rst_n),
        .char_i      (char_in),
        .char_stb_i  (char_stb),
        .char_rdy_o  (rdy),
        .wbm_adr_o   (adr),
        .wbm_dat_o   (dat),
        .wbm_dat_i   (rdata),
        .wbm_cyc_o   (cyc),
        .wbm_stb_o   (stb),
        .wbm_we_o    (we),
        .wbm_sel_o   (sel),
        .wbm_ack_i   (ack),
        .cursor_o    (cursor),
        .cursor_on_o (cursor_on),
        .flash_o     (flash)
    );

    always #5 clk = ~clk;

    int total = 0;
    int passed = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", nm, act, act, exp, exp);
    endtask

    // ---------------- VRAM slave ----------------
    typedef struct { bit w; int a; int s; int d; } op_t;
    op_t        ops[$];
    logic [7:0] mem [0:2047];
    bit         mem_init_done = 1'b0;
    bit         stall = 1'b0;
    bit         rand_lat = 1'b0;
    int         lat_cnt = 0;
    int         addr_err = 0;

    function automatic int rel(input logic [15:0] a);
        logic [15:0] d;
        d = a - BASE;
        return int'(d);
    endfunction

    function automatic int widx(input logic [15:0] a);
        return rel(a) & 2046;
    endfunction

    always @(posedge clk) begin
        if (!mem_init_done) begin
            for (int i = 0; i < 2048; i++) mem[i] <= 8'($urandom);
            mem_init_done <= 1'b1;
        end
        ack <= 1'b0;
        if (rst_n && cyc && stb && !ack && !stall) begin
            if (lat_cnt != 0) lat_cnt <= lat_cnt - 1;
            else begin
                ack     <= 1'b1;
                lat_cnt <= rand_lat ? int'($urandom_range(0, 1)) : 0;
                if (rel(adr) > 1999 || (we && rel(adr) < 80) || sel == 2'b00 ||
                    (sel != 2'b11 && ((rel(adr) % 2 == 0) != (sel == 2'b01))) ||
                    (sel == 2'b11 && rel(adr) % 2 != 0))
                    addr_err <= addr_err + 1;
                if (we) begin
                    if (sel[0]) mem[widx(adr)]     <= dat[7:0];
                    if (sel[1]) mem[widx(adr) + 1] <= dat[15:8];
                    ops.push_back(op_t'{1'b1, int'(adr), int'(sel), int'(dat)});
                end else begin
                    rdata <= {mem[widx(adr) + 1], mem[widx(adr)]};
                    ops.push_back(op_t'{1'b0, int'(adr), int'(sel),
                                        int'({mem[widx(adr) + 1], mem[widx(adr)]})});
                end
            end
        end
    end

    // ---------------- bus protocol monitor ----------------
    int          proto_err = 0;
    logic        p_cyc = 1'b0;
    logic        p_ack = 1'b0;
    logic [34:0] p_bus = '0;

    always @(negedge clk) begin
        if (rst_n) begin
            if (stb != cyc || (cyc && rdy) || rdy != cursor_on ||
                (p_cyc && p_ack && cyc) ||
                (p_cyc && !p_ack && cyc && {adr, dat, sel, we} != p_bus))
                proto_err <= proto_err + 1;
            p_cyc <= cyc;
            p_ack <= ack;
            p_bus <= {adr, dat, sel, we};
        end else begin
            p_cyc <= 1'b0;
            p_ack <= 1'b0;
        end
    end

    initial begin
        repeat (150000) @(posedge clk);
        $display("FAIL watchdog: got 150000 cycles expected completion");
        $fatal(1, "watchdog expired");
    end

    // ---------------- screen reference model ----------------
    logic [7:0] scr [0:1999];
    int mrow = 1;
    int mcol = 0;

    task automatic model_scroll();
        for (int i = 80; i < 1920; i++) scr[i] = scr[i + 80];
        for (int i = 1920; i < 2000; i++) scr[i] = 8'h20;
    endtask

    task automatic model_char(input logic [7:0] c);
        if (c >= 8'h20) begin
            scr[mrow * 80 + mcol] = c;
            if (mcol < 79) mcol++;
            else begin
                mcol = 0;
                if (mrow < 24) mrow++;
                else model_scroll();
            end
        end else if (c == 8'h0D) mcol = 0;
        else if (c == 8'h0A) begin
            if (mrow < 24) mrow++;
            else model_scroll();
        end else if (c == 8'h08) begin
            if (mcol > 0) mcol--;
        end else if (c == 8'h0C) begin
            for (int i = 80; i < 2000; i++) scr[i] = 8'h20;
            mrow = 1;
            mcol = 0;
        end
    endtask

    task automatic cmp_screen(input string nm);
        int bad = 0;
        for (int i = 0; i < 2000; i++) if (mem[i] !== scr[i]) bad++;
        chk(nm, bad, 0);
    endtask

    // ---------------- stimulus helpers (always entered/left on a negedge) ----------------
    task automatic start_char(input logic [7:0] c);
        int n = 0;
        while (!rdy && n < 20000) begin @(negedge clk); n++; end
        if (n >= 20000) chk("ready_wait", rdy, 1);
        char_in  = c;
        char_stb = 1'b1;
        @(posedge clk);
        @(negedge clk);
        char_stb = 1'b0;
        char_in  = 8'($urandom);
        model_char(c);
    endtask

    task automatic wait_idle();
        int n = 0;
        while (!rdy && n < 20000) begin @(negedge clk); n++; end
        if (n >= 20000) chk("idle_wait", rdy, 1);
    endtask

    task automatic send_char(input logic [7:0] c);
        start_char(c);
        wait_idle();
        $display("tx char=%02h cursor=%0d rdy=%0b bus_ops=%0d", c, cursor, rdy, ops.size());
    endtask

    typedef struct { logic [7:0] code; int cur; int nops; int adr; int sel; } vec_t;
    vec_t tbl [14];

    initial begin
        int ob, good, hi, n;
        logic [7:0] line [80];

        tbl[0]  = '{8'h41, 81,  1, 80,  1};
        tbl[1]  = '{8'h0D, 80,  0, 0,   0};
        tbl[2]  = '{8'h08, 80,  0, 0,   0};
        tbl[3]  = '{8'h08, 80,  0, 0,   0};
        tbl[4]  = '{8'h58, 81,  1, 80,  1};
        tbl[5]  = '{8'h08, 80,  0, 0,   0};
        tbl[6]  = '{8'h07, 80,  0, 0,   0};
        tbl[7]  = '{8'h0A, 160, 0, 0,   0};
        tbl[8]  = '{8'h42, 161, 1, 160, 1};
        tbl[9]  = '{8'h43, 162, 1, 161, 2};
        tbl[10] = '{8'h08, 161, 0, 0,   0};
        tbl[11] = '{8'h0D, 160, 0, 0,   0};
        tbl[12] = '{8'h1F, 160, 0, 0,   0};
        tbl[13] = '{8'h00, 160, 0, 0,   0};

        // Asynchronous reset, checked before any clock edge.
        #1 rst_n = 1'b0;
        #3;
        chk("rst_cyc", cyc, 0);
        chk("rst_stb", stb, 0);
        chk("rst_we", we, 0);
        chk("rst_sel", sel, 0);
        chk("rst_adr", adr, 0);
        chk("rst_dat", dat, 0);
        chk("rst_cursor", cursor, 80);
        chk("rst_rdy", rdy, 1);
        chk("rst_cursor_on", cursor_on, 1);
        chk("rst_flash", flash, 0);

        while (!mem_init_done) @(negedge clk);
        @(negedge clk);
        for (int i = 0; i < 2000; i++) scr[i] = mem[i];
        rst_n = 1'b1;

        // Blink phase: toggles on every 4th edge after reset release.
        for (int k = 1; k <= 16; k++) begin
            @(negedge clk);
            chk("flash_phase", flash, (k / 4) % 2);
        end

        // Directed vector table.
        for (int i = 0; i < 14; i++) begin
            ob = ops.size();
            send_char(tbl[i].code);
            chk("tbl_cursor", cursor, tbl[i].cur);
            chk("tbl_nops", ops.size() - ob, tbl[i].nops);
            chk("tbl_rdy", rdy, 1);
            if (tbl[i].nops == 1 && ops.size() == ob + 1) begin
                chk("tbl_adr", ops[ob].a, int'(BASE) + tbl[i].adr);
                chk("tbl_sel", ops[ob].s, tbl[i].sel);
                chk("tbl_dat", ops[ob].d, {16'd0, tbl[i].code, tbl[i].code});
            end
        end

        // Missing ack stalls the write with the bus held.
        ob = ops.size();
        stall = 1'b1;
        start_char(8'h53);
        repeat (40) @(negedge clk);
        chk("stall_cyc", cyc, 1);
        chk("stall_rdy", rdy, 0);
        chk("stall_cursor_on", cursor_on, 0);
        chk("stall_adr", adr, BASE + 16'd160);
        chk("stall_nops", ops.size() - ob, 0);
        stall = 1'b0;
        wait_idle();
        chk("stall_cursor", cursor, 161);

        // Form feed clears the whole text area.
        ob = ops.size();
        send_char(8'h0C);
        chk("clr_nops", ops.size() - ob, 960);
        good = 0;
        for (int i = 0; i < 960 && ob + i < ops.size(); i++)
            if (ops[ob + i].w && ops[ob + i].a == int'(BASE) + 80 + 2 * i &&
                ops[ob + i].s == 3 && ops[ob + i].d == 16'h2020) good++;
        chk("clr_ops", good, 960);
        chk("clr_cursor", cursor, 80);
        cmp_screen("clr_screen");

        // A full row of printable characters on row 1.
        ob = ops.size();
        for (int i = 0; i < 80; i++) begin
            line[i] = 8'($urandom_range(32, 126));
            send_char(line[i]);
        end
        good = 0;
        for (int i = 0; i < 80 && ob + i < ops.size(); i++)
            if (ops[ob + i].w && ops[ob + i].a == int'(BASE) + 80 + i &&
                ops[ob + i].s == ((i % 2 == 0) ? 1 : 2) &&
                ops[ob + i].d == {16'd0, line[i], line[i]}) good++;
        chk("row_ops", good, 80);
        chk("row_nops", ops.size() - ob, 80);
        chk("row_cursor", cursor, 160);

        // Move to row 24 col 5, then line feed forces a scroll.
        for (int i = 0; i < 22; i++) send_char(8'h0A);
        for (int i = 0; i < 5; i++) send_char(8'($urandom_range(32, 126)));
        chk("pre_scroll_cursor", cursor, 1925);
        ob = ops.size();
        start_char(8'h0A);
        hi = 0;
        n = 0;
        while (!(rdy && ops.size() >= ob + 1880) && n < 30000) begin
            if (rdy) hi++;
            @(negedge clk);
            n++;
        end
        if (n >= 30000) chk("scroll_wait", rdy, 1);
        chk("scroll_rdy_low", hi, 0);
        chk("scroll_nops", ops.size() - ob, 1880);
        if (ops.size() == ob + 1880) begin
            chk("scroll_first_rd", ops[ob].a, int'(BASE) + 160);
            chk("scroll_first_wr", ops[ob + 1].a, int'(BASE) + 80);
            chk("scroll_last_rd", ops[ob + 1838].a, int'(BASE) + 1998);
            chk("scroll_last_wr", ops[ob + 1839].a, int'(BASE) + 1918);
            good = 0;
            for (int i = 0; i < 920; i++)
                if (!ops[ob + 2 * i].w && ops[ob + 2 * i].a == int'(BASE) + 160 + 2 * i &&
                    ops[ob + 2 * i].s == 3 && ops[ob + 2 * i + 1].w &&
                    ops[ob + 2 * i + 1].a == int'(BASE) + 80 + 2 * i &&
                    ops[ob + 2 * i + 1].s == 3 &&
                    ops[ob + 2 * i + 1].d == ops[ob + 2 * i].d) good++;
            chk("scroll_pairs", good, 920);
            good = 0;
            for (int i = 0; i < 40; i++)
                if (ops[ob + 1840 + i].w && ops[ob + 1840 + i].a == int'(BASE) + 1920 + 2 * i &&
                    ops[ob + 1840 + i].s == 3 && ops[ob + 1840 + i].d == 16'h2020) good++;
            chk("scroll_tail", good, 40);
        end
        chk("scroll_cursor", cursor, 1925);
        cmp_screen("scroll_screen");

        // Reset in the middle of a scroll abandons it at once.
        start_char(8'h0A);
        repeat (300) @(negedge clk);
        n = 0;
        while (!cyc && n < 100) begin @(negedge clk); n++; end
        chk("midscroll_busy", cyc, 1);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("midrst_cyc", cyc, 0);
        chk("midrst_cursor", cursor, 80);
        chk("midrst_rdy", rdy, 1);
        ob = ops.size();
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (60) @(negedge clk);
        chk("midrst_no_ops", ops.size() - ob, 0);
        chk("midrst_cursor_after", cursor, 80);
        for (int i = 0; i < 2000; i++) scr[i] = mem[i];
        mrow = 1;
        mcol = 0;

        // Randomized stream against the screen model, with jittered ack latency.
        rand_lat = 1'b1;
        for (int i = 0; i < 21; i++) send_char(8'h0A);
        for (int i = 0; i < 100; i++) begin
            int r;
            logic [7:0] c;
            r = int'($urandom_range(0, 99));
            if (r < 72)      c = 8'($urandom_range(32, 255));
            else if (r < 80) c = 8'h0D;
            else if (r < 88) c = 8'h08;
            else if (r < 94) c = 8'h0A;
            else if (r < 95) c = 8'h0C;
            else begin
                c = 8'($urandom_range(0, 31));
                if (c == 8'h08 || c == 8'h0A || c == 8'h0C || c == 8'h0D) c = 8'h1B;
            end
            repeat ($urandom_range(0, 2)) @(negedge clk);
            send_char(c);
            chk("rand_cursor", cursor, mrow * 80 + mcol);
        end
        cmp_screen("rand_screen");

        chk("protocol", proto_err, 0);
        chk("addr_lanes", addr_err, 0);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/tty_writer.md
TTY_WRITER -- requirements
Module: tty_writer

Interface
REQ-001 Parameter BASE, default 16'o0: bus byte address of VRAM byte 0, added to every master address.
REQ-002 Parameter FLASH_DIV, default 24'd12500000: clock cycles per flash_o half-period.
REQ-003 wb_clk_i  in  1  clock; all logic on its rising edge.
REQ-004 wb_rst_n_i  in  1  reset; asynchronous and active-low.
REQ-005 char_i  in  8  character code from the upstream source.
REQ-006 char_stb_i  in  1  character valid.
REQ-007 char_rdy_o  out  1  block accepts char_i this cycle.
REQ-008 wbm_adr_o  out  16  master byte address.
REQ-009 wbm_dat_o  out  16  write data.
REQ-010 wbm_dat_i  in  16  read data.
REQ-011 wbm_cyc_o, wbm_stb_o, wbm_we_o  out  1 each  master cycle, strobe and write enable.
REQ-012 wbm_sel_o  out  2  byte lanes.
REQ-013 wbm_ack_i  in  1  slave acknowledge.
REQ-014 cursor_o  out  11  linear VRAM byte address of the cursor.
REQ-015 cursor_on_o  out  1  cursor visible.
REQ-016 flash_o  out  1  blink phase for the display.

Function
REQ-017 Screen is 25 rows x 80 bytes (0..1999); row 0 is the status line and is never written; the text area is rows 1..24 (bytes 80..1999).
REQ-018 State registers: row (1..24), col (0..79), cur = row*80+col, kept incrementally with no multiplier; cursor_o = cur.
REQ-019 FSM states: IDLE, WRCH, SCR_RD, SCR_WR, CLR; char_rdy_o = 1 only in IDLE, and a handshake is char_stb_i & char_rdy_o.
REQ-020 Accepted code >= 0x20: WRCH writes the byte at cur, then col+1; at col 79 it goes to col 0 and row+1; at row 24 col 79 it goes to col 0 and starts a scroll.
REQ-021 0x0D: col <= 0, no bus cycle, stays in IDLE.
REQ-022 0x0A: if row < 24, row+1 with col unchanged; at row 24, start a scroll with row and col unchanged.
REQ-023 0x08: if col > 0, col-1; at col 0, no change.
REQ-024 0x0C: enters CLR over the whole text area, then row = 1, col = 0.
REQ-025 All other codes 0x00-0x1F are discarded without any bus cycle.
REQ-026 Byte writes: wbm_adr_o = BASE+addr; wbm_sel_o = 2'b01 for even addr, 2'b10 for odd addr; wbm_dat_o = {char,char}.
REQ-027 Scroll loop: for word address w = 80, 82, ..., 1918, SCR_RD reads BASE+w+80 (sel 2'b11) and latches wbm_dat_i on ack, then SCR_WR writes it to BASE+w (sel 2'b11). This is 920 read/write pairs.
REQ-028 After the last scroll pair, CLR writes 16'h2020 (sel 2'b11) to words 1920..1998 (40 writes); after a 0x0C, CLR covers words 80..1998 (960 writes).
REQ-029 Bus handshake: cyc_o and stb_o rise together and hold with constant adr, dat, sel and we until the cycle in which wbm_ack_i = 1; they drop on the next edge and stay low for at least one cycle before the next access.
REQ-030 There is no timeout; a missing ack stalls the FSM, with char_rdy_o = 0.
REQ-031 cursor_on_o = 1 in IDLE and 0 in every other state.
REQ-032 Flash: a 24-bit counter runs continuously; at FLASH_DIV-1 it wraps to 0 and toggles flash_o.
REQ-033 A handshake is accepted in the cycle it occurs; the next character can be accepted no sooner than one cycle after a write cycle completes.

Reset
REQ-034 While wb_rst_n_i = 0, all of the following hold asynchronously:
- FSM = IDLE; row = 1, col = 0, cursor_o = 11'd80;
- wbm_cyc_o, wbm_stb_o, wbm_we_o = 0; wbm_sel_o = 0; wbm_adr_o = 0; wbm_dat_o = 0;
- flash_o = 0, flash counter = 0; char_rdy_o = 1, cursor_on_o = 1.
REQ-035 Reset in the middle of a scroll or clear abandons it immediately, with no further bus cycles; VRAM content is left as is.

Verification
REQ-036 Slave acks one cycle after stb; send 'A' (0x41) after reset -> one write with adr=BASE+80, sel=01, dat=4141; afterwards cursor_o=81 and char_rdy_o returns to 1.
REQ-037 Send 80 printable characters at row 1 -> 80 writes to 80..159, alternating sel 01/10; final cursor_o=160 (row 2, col 0).
REQ-038 Send 0x0D, 0x08, 0x08 at col 0 -> no bus cycles; cursor_o unchanged. Then send 'X', 0x08 -> cursor_o back to 80.
REQ-039 Cursor at row 24 col 5, send 0x0A -> 920 read/write pairs (first read 160 then write 80, last read 1998 then write 1918), then 40 writes of 2020 at 1920..1998; cursor_o = 1925; char_rdy_o = 0 throughout.
REQ-040 Send 0x0C -> 960 writes of 2020 at 80..1998; cursor_o = 80. Separately, pulse wb_rst_n_i low mid-scroll -> cyc_o drops asynchronously, no further accesses, cursor_o = 80.
REQ-041 With FLASH_DIV = 4 -> flash_o toggles every 4 cycles from reset (period 8).
